// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of independent programmable clock dividers with shadowed
// divisors that retime at terminal count, plus a global phase-align strobe.
`default_nettype none

module clk_div_bank #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 18,
  parameter int DEFAULT_DIV = 4,
  parameter int SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              master_clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_all,
  input  logic              div_wr,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [CNT_W-1:0]  div_val,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pend,
  output logic              wr_err
);

  localparam logic [SEL_W:0]   NUM_CH_EXT = (SEL_W + 1)'(NUM_CH);
  localparam logic [CNT_W-1:0] DIV_RST    = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] DIV_MIN    = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  logic wr_ok;
  logic wr_err_d, wr_err_q;

  always_comb begin
    wr_ok    = div_wr && ({1'b0, div_sel} < NUM_CH_EXT) && (div_val >= DIV_MIN);
    wr_err_d = 1'b0;
    if (!reset) wr_err_d = div_wr && !wr_ok;
  end

  always_ff @(posedge master_clk) begin
    wr_err_q <= wr_err_d;
  end

  assign wr_err = wr_err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tc, restart, apply, wr_hit;

    always_comb begin
      tc       = (cnt_q == n_q - ONE);
      // A disabled or re-synced channel restarts its period from zero.
      restart  = sync_all || !ch_en[i];
      apply    = pend_q && (restart || tc);
      wr_hit   = wr_ok && (div_sel == SEL_W'(i));
      cnt_d    = cnt_q;
      n_d      = n_q;
      shadow_d = shadow_q;
      pend_d   = pend_q;
      clk_d    = 1'b0;
      if (reset) begin
        cnt_d    = '0;
        n_d      = DIV_RST;
        shadow_d = DIV_RST;
        pend_d   = 1'b0;
      end else begin
        if (restart || tc) cnt_d = '0;
        else               cnt_d = cnt_q + ONE;
        if (!restart) clk_d = (cnt_q < (n_q >> 1));
        // Apply uses the shadow as it stood before any same-cycle write.
        if (apply) n_d = shadow_q;
        if (wr_hit) begin
          shadow_d = div_val;
          pend_d   = 1'b1;
        end else if (apply) begin
          pend_d   = 1'b0;
        end
      end
    end

    always_ff @(posedge master_clk) begin
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      clk_q    <= clk_d;
    end

    assign clk_out[i] = clk_q;
    assign pend[i]    = pend_q;
    assign tick[i]    = ch_en[i] && tc && !sync_all && !reset;
  end

endmodule

`default_nettype wire

// File: tb/tb_clk_div_bank.sv
// Randomized bench for clk_div_bank, checked cycle by cycle against a
// period/phase reference model of each channel.
`default_nettype none

module tb_clk_div_bank;

  localparam int NCH = 3;
  localparam int CW  = 5;
  localparam int DEF = 4;

  logic           master_clk = 1'b0;
  logic           reset      = 1'b1;
  logic [NCH-1:0] ch_en      = '0;
  logic           sync_all   = 1'b0;
  logic           div_wr     = 1'b0;
  logic [1:0]     div_sel    = '0;
  logic [CW-1:0]  div_val    = '0;
  logic [NCH-1:0] clk_out, tick, pend;
  logic           wr_err;

  clk_div_bank #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_DIV(DEF)) dut (
    .master_clk(master_clk),
    .reset     (reset),
    .ch_en     (ch_en),
    .sync_all  (sync_all),
    .div_wr    (div_wr),
    .div_sel   (div_sel),
    .div_val   (div_val),
    .clk_out   (clk_out),
    .tick      (tick),
    .pend      (pend),
    .wr_err    (wr_err)
  );

  always #5 master_clk = ~master_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: each channel is a period length, a phase within the
  // period, a queued next period and the level of the output clock.
  int m_period[NCH];
  int m_queued[NCH];
  int m_phase[NCH];
  bit m_pend[NCH];
  bit m_clk[NCH];
  bit m_werr;
  int tick_count;

  function automatic logic [31:0] exp_tick();
    logic [31:0] v = '0;
    for (int i = 0; i < NCH; i++)
      v[i] = !reset && ch_en[i] && !sync_all && (m_phase[i] == m_period[i] - 1);
    return v;
  endfunction

  function automatic logic [31:0] exp_clk();
    logic [31:0] v = '0;
    for (int i = 0; i < NCH; i++) v[i] = m_clk[i];
    return v;
  endfunction

  function automatic logic [31:0] exp_pend();
    logic [31:0] v = '0;
    for (int i = 0; i < NCH; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_step();
    bit valid;
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        m_period[i] = DEF; m_queued[i] = DEF; m_phase[i] = 0;
        m_pend[i] = 0; m_clk[i] = 0;
      end
      m_werr = 0;
    end else begin
      valid  = (int'(div_sel) < NCH) && (int'(div_val) >= 2);
      m_werr = div_wr && !valid;
      for (int i = 0; i < NCH; i++) begin
        bit last, restart, app, nclk;
        int nphase;
        last    = ch_en[i] && (m_phase[i] == m_period[i] - 1);
        restart = sync_all || !ch_en[i];
        app     = m_pend[i] && (restart || last);
        nclk    = restart ? 1'b0 : (m_phase[i] < m_period[i] / 2);
        nphase  = (restart || last) ? 0 : m_phase[i] + 1;
        if (app) m_period[i] = m_queued[i];
        if (div_wr && valid && int'(div_sel) == i) begin
          m_queued[i] = int'(div_val);
          m_pend[i]   = 1;
        end else if (app) begin
          m_pend[i] = 0;
        end
        m_clk[i]   = nclk;
        m_phase[i] = nphase;
      end
    end
  endtask

  // Inputs are already driven (at a falling edge); check tick, advance the
  // model across the rising edge, then check registered outputs.
  task automatic step();
    #1;
    chk("tick", 32'(tick), exp_tick());
    if (tick[0]) tick_count++;
    model_step();
    @(negedge master_clk);
    chk("clk_out", 32'(clk_out), exp_clk());
    chk("pend", 32'(pend), exp_pend());
    chk("wr_err", 32'(wr_err), 32'(m_werr));
  endtask

  initial begin
    @(negedge master_clk);
    reset = 1'b1;
    step();
    step();
    chk("rst_clk_out", 32'(clk_out), 32'd0);
    chk("rst_pend", 32'(pend), 32'd0);
    reset = 1'b0;

    // Default divisor, all channels free-running.
    ch_en = '1;
    tick_count = 0;
    for (int c = 0; c < 1000; c++) step();
    chk("tick_count_n4", 32'(tick_count), 32'd250);

    for (int c = 0; c < 5000; c++) begin
      int r;
      reset    = ($urandom_range(0, 299) == 0);
      sync_all = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < NCH; i++)
        if ($urandom_range(0, 23) == 0) ch_en[i] = ~ch_en[i];
      div_wr  = ($urandom_range(0, 5) == 0);
      div_sel = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      if (r == 0)      div_val = CW'($urandom_range(0, 1));
      else if (r == 1) div_val = CW'($urandom_range(30, 31));
      else             div_val = CW'($urandom_range(2, 12));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
